// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount to a coin hopper, largest coin first,
// one coin per valid/ack handshake. Optional ack timeout via `define COIN_TIMEOUT_EN.
module change_dispenser #(
    parameter int AMT_W          = 4,
    parameter int CNT_W          = 6,
    parameter int STOCK_INIT1    = 10,
    parameter int STOCK_INIT2    = 10,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic             coin_type,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill,
    input  logic             refill_type,
    output logic [CNT_W-1:0] stock1,
    output logic [CNT_W-1:0] stock2
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("change_dispenser: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_reg;
    logic [AMT_W-1:0]   remaining_reg;
    logic               coin_valid_reg;
    logic               coin_type_reg;
    logic               done_reg;
    logic               short_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [1:0][CNT_W-1:0] stock_vec;

    logic               ack_take;
    logic [AMT_W-1:0]   sel_amt;
    logic               can_two;
    logic               can_one;
    logic               sel_ok;
    logic               sel_type;
    logic [AMT_W-1:0]   coin_value;
    logic [AMT_W-1:0]   rem_after;

    // An ack only counts while a coin is actually being offered.
    assign ack_take = (state_reg == ISSUE) && coin_ack;

    // In IDLE the selection looks at the incoming request so the first coin
    // (or an immediate DONE) is ready the cycle right after the accept.
    always_comb begin
        sel_amt  = (state_reg == IDLE) ? req_amount : remaining_reg;
        can_two  = (sel_amt >= AMT_W'(2)) && (stock_vec[1] != '0);
        can_one  = (sel_amt != '0) && (stock_vec[0] != '0);
        sel_ok   = can_two || can_one;
        sel_type = can_two;
    end

    assign coin_value = coin_type_reg ? AMT_W'(2) : AMT_W'(1);
    assign rem_after  = remaining_reg - coin_value;

    // One counter per coin type; index gi matches the coin_type encoding.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stock
        localparam logic [CNT_W-1:0] INIT_VAL =
            (gi == 0) ? CNT_W'(STOCK_INIT1) : CNT_W'(STOCK_INIT2);

        logic [CNT_W-1:0] cnt_reg;
        logic             refill_hit;
        logic             dispense_hit;

        assign refill_hit   = refill && (refill_type == 1'(gi));
        assign dispense_hit = ack_take && (coin_type_reg == 1'(gi));

        // Refill and dispense of the same type cancel out, so saturation
        // only matters for a lone refill.
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_reg <= INIT_VAL;
            end else if (refill_hit && !dispense_hit) begin
                if (cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else if (dispense_hit && !refill_hit) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end

        assign stock_vec[gi] = cnt_reg;
    end

`ifdef COIN_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_reg;
    logic            to_expired;

    assign to_expired = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            coin_valid_reg <= 1'b0;
            coin_type_reg  <= 1'b0;
            done_reg       <= 1'b0;
            short_reg      <= 1'b0;
            gap_cnt_reg    <= '0;
`ifdef COIN_TIMEOUT_EN
            to_cnt_reg     <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        remaining_reg <= req_amount;
                        if (sel_ok) begin
                            state_reg      <= ISSUE;
                            coin_valid_reg <= 1'b1;
                            coin_type_reg  <= sel_type;
`ifdef COIN_TIMEOUT_EN
                            to_cnt_reg     <= '0;
`endif
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            short_reg <= (req_amount != '0);
                        end
                    end
                end

                ISSUE: begin
                    if (coin_ack) begin
                        coin_valid_reg <= 1'b0;
                        remaining_reg  <= rem_after;
                        if (rem_after == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            short_reg <= 1'b0;
                        end else begin
                            state_reg   <= GAP;
                            gap_cnt_reg <= GAP_W'(GAP_CYCLES - 1);
                        end
                    end
`ifdef COIN_TIMEOUT_EN
                    // An ack arriving on the expiry cycle takes priority above.
                    else if (to_expired) begin
                        coin_valid_reg <= 1'b0;
                        state_reg      <= DONE;
                        done_reg       <= 1'b1;
                        short_reg      <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
`endif
                end

                GAP: begin
                    if (gap_cnt_reg == '0) begin
                        if (sel_ok) begin
                            state_reg      <= ISSUE;
                            coin_valid_reg <= 1'b1;
                            coin_type_reg  <= sel_type;
`ifdef COIN_TIMEOUT_EN
                            to_cnt_reg     <= '0;
`endif
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            short_reg <= (remaining_reg != '0);
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign coin_valid = coin_valid_reg;
    assign coin_type  = coin_type_reg;
    assign done       = done_reg;
    assign short      = short_reg;
    assign remaining  = remaining_reg;
    assign stock1     = stock_vec[0];
    assign stock2     = stock_vec[1];

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a transaction-level greedy payout model.
module tb_change_dispenser;

    localparam int AMT_W   = 4;
    localparam int CNT_W   = 6;
    localparam int GAP     = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amount = '0;
    logic             req_ready;
    logic             coin_valid;
    logic             coin_type;
    logic             coin_ack = 1'b0;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic             refill = 1'b0;
    logic             refill_type = 1'b0;
    logic [CNT_W-1:0] stock1;
    logic [CNT_W-1:0] stock2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model stock counts
    int m_s1 = 10;
    int m_s2 = 10;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_ack   (coin_ack),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .refill     (refill),
        .refill_type(refill_type),
        .stock1     (stock1),
        .stock2     (stock2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_refill(input bit t);
        if (t) m_s2 = (m_s2 + 1 > CNT_MAX) ? CNT_MAX : m_s2 + 1;
        else   m_s1 = (m_s1 + 1 > CNT_MAX) ? CNT_MAX : m_s1 + 1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", int'(req_ready), 1);
    endtask

    // One full change request. fixed_delay < 0 picks a random ack delay.
    task automatic run_req(input int amount, input int fixed_delay, input bit noise,
                           input bit ack_refill);
        int  rem;
        int  coins;
        int  d;
        bit  c1, c2, ctype;
        rem   = amount;
        coins = 0;
        wait_ready();
        req_valid  = 1'b1;
        req_amount = AMT_W'(amount);
        tick();
        req_valid = 1'b0;
        forever begin
            c2 = (rem >= 2) && (m_s2 > 0);
            c1 = (rem >= 1) && (m_s1 > 0);
            if (!(c1 || c2)) break;
            ctype = c2;
            check("coin_valid", int'(coin_valid), 1);
            check("coin_type", int'(coin_type), int'(ctype));
            d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 5));
            for (int k = 0; k < d; k++) begin
                if (noise) begin
                    req_valid  = 1'($urandom);
                    req_amount = AMT_W'($urandom);
                    refill     = ($urandom_range(0, 3) == 0);
                    refill_type = 1'($urandom);
                    if (refill) model_refill(refill_type);
                end
                tick();
                refill = 1'b0;
                check("hold_valid", int'(coin_valid), 1);
                check("hold_type", int'(coin_type), int'(ctype));
                check("hold_done", int'(done), 0);
            end
            coin_ack = 1'b1;
            if (ack_refill) begin
                refill      = 1'b1;
                refill_type = ctype;
            end
            tick();
            coin_ack = 1'b0;
            refill   = 1'b0;
            coins++;
            rem = rem - (ctype ? 2 : 1);
            if (ctype) m_s2--; else m_s1--;
            if (ack_refill) model_refill(ctype);
            if (rem == 0) break;
            check("gap_valid", int'(coin_valid), 0);
            for (int g = 0; g < GAP; g++) begin
                coin_ack  = noise ? 1'($urandom) : 1'b0;
                req_valid = noise ? 1'($urandom) : 1'b0;
                tick();
                if (g < GAP - 1) check("gap_valid", int'(coin_valid), 0);
            end
            coin_ack = 1'b0;
        end
        req_valid = 1'b0;
        check("done", int'(done), 1);
        check("short", int'(short), int'(rem != 0));
        check("remaining", int'(remaining), rem);
        check("done_valid", int'(coin_valid), 0);
        check("stock1", int'(stock1), m_s1);
        check("stock2", int'(stock2), m_s2);
        $display("txn amount=%0d coins=%0d remaining=%0d short=%0d stock1=%0d stock2=%0d",
                 amount, coins, rem, int'(rem != 0), m_s1, m_s2);
        tick();
        check("done_pulse", int'(done), 0);
        check("ready_after", int'(req_ready), 1);
        check("rem_hold", int'(remaining), rem);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        tick();
        tick();
        check("rst_ready", int'(req_ready), 1);
        check("rst_valid", int'(coin_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_stock1", int'(stock1), 10);
        check("rst_stock2", int'(stock2), 10);
        rst = 1'b1;
        tick();

        // Greedy 5 -> 2,2,1 with immediate acks
        run_req(5, 0, 1'b0, 1'b0);
        check("s5_stock1", int'(stock1), 9);
        check("s5_stock2", int'(stock2), 8);

        // Zero amount completes right away
        run_req(0, 0, 1'b0, 1'b0);

        // Long ack hold with same-type refill in the ack cycle
        run_req(2, 6, 1'b0, 1'b1);

        // Reset while the second coin is on offer
        wait_ready();
        req_valid  = 1'b1;
        req_amount = AMT_W'(4);
        tick();
        req_valid = 1'b0;
        check("rs_valid", int'(coin_valid), 1);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        for (int g = 0; g < GAP; g++) tick();
        check("rs_valid2", int'(coin_valid), 1);
        check("rs_rem", int'(remaining), 2);
        rst = 1'b0;
        tick();
        m_s1 = 10;
        m_s2 = 10;
        check("rs_after_valid", int'(coin_valid), 0);
        check("rs_after_rem", int'(remaining), 0);
        check("rs_after_s1", int'(stock1), 10);
        check("rs_after_s2", int'(stock2), 10);
        rst = 1'b1;
        tick();
        check("rs_ready", int'(req_ready), 1);

`ifdef COIN_TIMEOUT_EN
        wait_ready();
        req_valid  = 1'b1;
        req_amount = AMT_W'(2);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (coin_valid && n < 40) begin
            n++;
            tick();
        end
        check("to_len", n, 15);
        check("to_done", int'(done), 1);
        check("to_short", int'(short), 1);
        check("to_rem", int'(remaining), 2);
        check("to_stock2", int'(stock2), m_s2);
        tick();
        check("to_ready", int'(req_ready), 1);
`endif

        // Random traffic; stocks drain so shortfalls show up
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 2));
            for (int r = 0; r < n; r++) begin
                refill      = 1'b1;
                refill_type = 1'($urandom);
                model_refill(refill_type);
                tick();
                refill = 1'b0;
                check("idle_s1", int'(stock1), m_s1);
                check("idle_s2", int'(stock2), m_s2);
            end
            run_req(int'($urandom_range(0, 15)), -1, 1'b1, 1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Return-money counterpart of the coin-accepting vending FSM: pays out a change amount as a sequence of physical coins to a coin hopper.
- Takes a change request in coin units, picks coins greedily from two internal stock counters, and issues one coin at a time over a valid/ack handshake.
- Reports completion and any shortfall.
- coin_type encoding is shared with the acceptor side: 0 = 1-unit coin, 1 = 2-unit coin.

Parameters:
- AMT_W, 4, width of request amount and remaining count (units).
- CNT_W, 6, width of each stock counter.
- STOCK_INIT1, 10, 1-unit coin stock loaded at reset.
- STOCK_INIT2, 10, 2-unit coin stock loaded at reset.
- GAP_CYCLES, 2, idle cycles between coins; must be ≥1.
- TIMEOUT_CYCLES, 15, ack timeout; used only with COIN_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  change to pay, in units.
- req_ready  out  1  high only in IDLE.
- coin_valid  out  1  coin issue request to hopper.
- coin_type  out  1  0 = 1-unit, 1 = 2-unit; stable while coin_valid is high.
- coin_ack  in  1  hopper has dropped the coin.
- done  out  1  one-cycle completion pulse.
- short  out  1  valid with done; 1 = amount not fully paid.
- remaining  out  AMT_W  units still owed; holds its value after done until the next accept.
- refill  in  1  add one coin to stock.
- refill_type  in  1  type of the refilled coin.
- stock1, stock2  out  CNT_W  current stock counts.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - coin_valid, done, short and remaining go to 0.
  - stock1 = STOCK_INIT1 and stock2 = STOCK_INIT2.
  - Applies mid-operation; any in-flight coin is abandoned.
- States: IDLE, ISSUE, GAP, DONE.
- Accept cycle T: req_valid && req_ready. remaining loads req_amount.
- Coin selection, evaluated against the current remaining and stock:
  - remaining ≥ 2 and stock2 > 0 → type 1.
  - Otherwise, remaining ≥ 1 and stock1 > 0 → type 0.
  - Otherwise no coin is possible.
- IDLE → at T+1:
  - ISSUE with coin_valid = 1, if a coin is selectable.
  - DONE, if amount is 0 or no coin is possible.
- ISSUE:
  - Hold coin_valid and coin_type until coin_ack.
  - At ack cycle A: remaining decreases by the coin value and the chosen stock decrements.
  - Next state: DONE at A+1 if the new remaining = 0; otherwise GAP.
- GAP: coin_valid = 0 for GAP_CYCLES cycles. At A+GAP_CYCLES+1, apply selection again → ISSUE or DONE.
- DONE: done = 1 for exactly one cycle; short = (remaining ≠ 0). Then IDLE, with req_ready high the following cycle.
- coin_ack outside ISSUE is ignored.
- req_valid outside IDLE is ignored; the request is not latched.
- Refill: the matching stock increments and saturates at 2^CNT_W−1.
- Refill and dispense of the same type in the same cycle: net change is zero.
- Refill in any state, including reset-free DONE/ISSUE, takes effect next cycle and is visible to the next selection.
- Arithmetic: remaining never underflows, because a type-1 coin is chosen only when remaining ≥ 2.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Defined: in ISSUE, a counter runs from the cycle coin_valid rises. If TIMEOUT_CYCLES cycles pass without coin_ack:
  - coin_valid drops, with no stock or remaining change.
  - Next state is DONE with short = 1.
  - An ack in the same cycle as expiry wins.
- Undefined: ISSUE waits for coin_ack indefinitely; no counter logic is present.

Test Plan:
- Defaults, accept amount 5 with ack same cycle as valid → coins type 1, 1, 0, each separated by 2 idle cycles; done with short=0, remaining=0, stock2=8, stock1=9.
- Accept amount 0 at T → done at T+1, short=0, coin_valid never rises.
- STOCK_INIT2=0, amount 3 → three type-0 coins; then STOCK_INIT1=1, STOCK_INIT2=0, amount 3 → one coin, done with short=1, remaining=2, stock1=0.
- Ack withheld 6 cycles with refill of type 1 pulsed in the ack cycle while dispensing type 1 → coin_valid and coin_type held stable; stock2 unchanged after the ack.
- rst=0 during ISSUE, after one coin already paid → next cycle coin_valid=0, remaining=0, stocks back to 10/10, req_ready=1 after rst returns high.
- With COIN_TIMEOUT_EN, amount 2 and no ack → coin_valid drops after 15 cycles; done with short=1, remaining=2, stock2=10.
